rs_tx_feeder: RTL and testbench
===============================

# rs_tx_feeder

Return-path sequencer for the Reed-Solomon link: accepts decoded bytes from the RS decoder (`output_byte`/`output_valid` side), buffers them in a small FIFO, and hands them one at a time to the UART transmitter with a write-strobe/busy handshake. It mirrors the receive-side FSM, which turns UART Rx bytes into decoder clock-enables, and it closes the loop back to the host. It also counts transmitted bytes per codeword frame and flags frame completion and FIFO overflow.

## Interface
- `DEPTH`, 16: FIFO depth in bytes; power of 2, minimum 2.
- `FRAME_LEN`, 207: bytes per frame; range 1..255.

- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high; one clock, reset synchronous and active-high.
- `dec_byte`  in  8  decoded byte from the RS decoder.
- `dec_valid`  in  1  `dec_byte` is valid this cycle; single-cycle qualifier, no backpressure.
- `Tx_DATA`  out  8  byte to the UART transmitter.
- `Tx_WR`  out  1  one-cycle start strobe to the UART transmitter.
- `Tx_BUSY`  in  1  UART transmitter is shifting a byte.
- `fifo_count`  out  log2(DEPTH)+1  current FIFO occupancy.
- `overflow`  out  1  sticky flag: a byte was dropped.
- `frame_done`  out  1  one-cycle pulse after the last byte of a frame completes.
- `busy`  out  1  high when the FSM is not in IDLE or the FIFO is not empty.

## Operation
- Reset values: `Tx_DATA`=0, `Tx_WR`=0, `fifo_count`=0, `overflow`=0, `frame_done`=0, FSM=IDLE, frame counter=0, FIFO pointers=0. Reset mid-transfer discards FIFO contents and any pending byte; the UART is not notified.
- FIFO write: on `dec_valid`=1, accept the byte if `fifo_count`<DEPTH, or if a pop happens in the same cycle.
- If the FIFO is full with no pop, drop the byte and set `overflow`. `overflow` stays set until reset.
- FIFO pointers wrap modulo DEPTH. A simultaneous push and pop leaves `fifo_count` unchanged.
- FSM states:
  - IDLE: if `fifo_count`≠0, go to LOAD.
  - LOAD: pop the FIFO head into the `Tx_DATA` register; go to STROBE.
  - STROBE: `Tx_WR`=1 for exactly this cycle; go to WAIT_BUSY.
  - WAIT_BUSY: stay until `Tx_BUSY`=1, then go to WAIT_DONE.
  - WAIT_DONE: stay until `Tx_BUSY`=0. On exit, increment the frame counter and go to IDLE.
- Frame counter is 8-bit. When an increment would reach FRAME_LEN, reset it to 0 and pulse `frame_done` in the following cycle, which is the IDLE cycle.
- `Tx_DATA` holds its value from LOAD until the next LOAD. `Tx_WR` is driven from a register, never combinationally.
- `Tx_BUSY` is ignored in IDLE, LOAD and STROBE.

## Timing
- Push latency: `dec_valid` at cycle 0 into an empty FIFO with the FSM in IDLE gives `fifo_count`=1 at cycle 1, LOAD at cycle 2, and `Tx_WR`=1 with `Tx_DATA` valid at cycle 3.
- Inter-byte gap: `Tx_BUSY` seen low in WAIT_DONE at cycle n gives IDLE at n+1, LOAD at n+2, and the next `Tx_WR` at n+3.
- Minimum handshake overhead is 4 cycles per byte plus the UART busy time.
- `frame_done` pulses in the cycle after WAIT_DONE exits for byte number FRAME_LEN.
- `dec_valid` may be asserted every cycle. Sustained input faster than the UART overflows the FIFO; this is by design and is reported via `overflow`.

## Test plan
- Reset, then one byte 0xA5 on `dec_valid` at cycle 0 -> `Tx_WR`=1 at cycle 3 with `Tx_DATA`=0xA5. Model `Tx_BUSY` high for 10 cycles -> `fifo_count` returns to 0 and `busy`=0 after the FSM returns to IDLE.
- Burst of 5 bytes 0x01..0x05 in consecutive cycles -> exactly 5 `Tx_WR` pulses, in order 0x01..0x05, each separated by the busy time plus 3 cycles; `overflow`=0.
- DEPTH=16, UART held busy, push 17 bytes -> `fifo_count`=16 and `overflow`=1. The 17th byte is never transmitted; the first 16 arrive in order.
- FIFO full, with `dec_valid` in the same cycle as a LOAD pop -> byte accepted, `fifo_count` stays 16, `overflow` stays 0.
- FRAME_LEN=3, send 7 bytes -> `frame_done` pulses after the 3rd and 6th completions only; the frame counter is 1 at the end.
- Assert `reset` while in WAIT_DONE with 4 bytes queued -> next cycle all outputs are at reset values; `Tx_BUSY` falling afterwards produces no `Tx_WR`.

Source files
------------

// File: rtl/rs_tx_feeder.sv
// Return-path sequencer: buffers decoded RS bytes in a small FIFO and feeds them
// one at a time to the UART transmitter using a write-strobe / busy handshake.
// Also counts transmitted bytes per frame and flags frame completion and overflow.
module rs_tx_feeder #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned FRAME_LEN = 207
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               dec_byte,
    input  logic                     dec_valid,
    output logic [7:0]               Tx_DATA,
    output logic                     Tx_WR,
    input  logic                     Tx_BUSY,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic                     frame_done,
    output logic                     busy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FullCount = DEPTH[AW:0];
    localparam logic [7:0]  FrameLast = 8'(FRAME_LEN - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStrobe,
        StWaitBusy,
        StWaitDone
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     count_q;
    logic [7:0]      tx_data_q;
    logic            tx_wr_q;
    logic            overflow_q;
    logic            frame_done_q;
    logic [7:0]      frame_cnt_q, frame_cnt_d;
    logic            pop, push, full;
    logic            done_exit, frame_wrap;

    assign full = (count_q == FullCount);
    assign pop  = (state_q == StLoad);
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign push = dec_valid && (!full || pop);

    // FIFO storage; no reset needed, occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= dec_byte;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (dec_valid && !push) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Next-state logic for the transmit handshake and the frame counter.
    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        done_exit   = 1'b0;
        frame_wrap  = (frame_cnt_q == FrameLast);
        case (state_q)
            StIdle:     if (count_q != '0) state_d = StLoad;
            StLoad:     state_d = StStrobe;
            StStrobe:   state_d = StWaitBusy;
            StWaitBusy: if (Tx_BUSY) state_d = StWaitDone;
            StWaitDone: begin
                if (!Tx_BUSY) begin
                    state_d   = StIdle;
                    done_exit = 1'b1;
                end
            end
            default:    state_d = StIdle;
        endcase
        if (done_exit) begin
            frame_cnt_d = frame_wrap ? 8'd0 : frame_cnt_q + 8'd1;
        end
    end

    // State register plus registered UART-facing outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            tx_data_q    <= 8'd0;
            tx_wr_q      <= 1'b0;
            frame_cnt_q  <= 8'd0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            // Strobe is registered from LOAD so it is high exactly during STROBE.
            tx_wr_q      <= (state_q == StLoad);
            if (pop) begin
                tx_data_q <= mem_q[rd_ptr_q];
            end
            frame_cnt_q  <= frame_cnt_d;
            frame_done_q <= done_exit && frame_wrap;
        end
    end

    assign Tx_DATA    = tx_data_q;
    assign Tx_WR      = tx_wr_q;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q != StIdle) || (count_q != '0);

endmodule

// File: tb/tb_rs_tx_feeder.sv
// Self-checking bench for rs_tx_feeder with a behavioural UART model.
module tb_rs_tx_feeder;

    localparam int DEPTH = 16;
    localparam int FLEN  = 3;

    logic       clk;
    logic       reset;
    logic [7:0] dec_byte;
    logic       dec_valid;
    logic [7:0] Tx_DATA;
    logic       Tx_WR;
    logic       Tx_BUSY;
    logic [4:0] fifo_count;
    logic       overflow;
    logic       frame_done;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;

    // UART model state
    int         busy_len  = 4;
    int         busy_left = 0;
    logic       uart_hold = 1'b0;
    logic [7:0] rx_data[$];
    int         rx_cyc[$];
    int         fd_cyc[$];

    rs_tx_feeder #(
        .DEPTH    (DEPTH),
        .FRAME_LEN(FLEN)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .dec_byte  (dec_byte),
        .dec_valid (dec_valid),
        .Tx_DATA   (Tx_DATA),
        .Tx_WR     (Tx_WR),
        .Tx_BUSY   (Tx_BUSY),
        .fifo_count(fifo_count),
        .overflow  (overflow),
        .frame_done(frame_done),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cycle++;
        end
    end

    // UART: on a write strobe, record the byte and stay busy for busy_len cycles.
    initial begin
        Tx_BUSY = 1'b0;
        forever begin
            @(negedge clk);
            if (Tx_WR === 1'b1) begin
                rx_data.push_back(Tx_DATA);
                rx_cyc.push_back(cycle);
                busy_left = busy_len;
            end else if (busy_left > 0) begin
                busy_left--;
            end
            if (frame_done === 1'b1) fd_cyc.push_back(cycle);
            Tx_BUSY = uart_hold || (busy_left > 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        rx_data.delete();
        rx_cyc.delete();
        fd_cyc.delete();
    endtask

    task automatic wait_rx(input int n, input int budget);
        for (int i = 0; i < budget && rx_data.size() < n; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({Tx_DATA, Tx_WR, fifo_count, overflow, frame_done, busy} !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h,%b,%0d,%b,%b,%b expected all zero",
                     Tx_DATA, Tx_WR, fifo_count, overflow, frame_done, busy);
        end
    endtask

    task automatic test_single();
        int c0;
        int b;
        do_reset();
        b = 10;
        busy_len = b;
        @(negedge clk);
        c0 = cycle;
        dec_byte  = 8'hA5;
        dec_valid = 1'b1;
        @(negedge clk);
        dec_valid = 1'b0;
        n_checks++;
        if (fifo_count !== 5'd1) begin
            n_fail++;
            $display("FAIL single_count1: got %0d expected 1", fifo_count);
        end
        @(negedge clk);
        n_checks++;
        if (Tx_WR !== 1'b0) begin
            n_fail++;
            $display("FAIL single_early_wr: got %b expected 0", Tx_WR);
        end
        @(negedge clk);
        n_checks++;
        if (Tx_WR !== 1'b1 || Tx_DATA !== 8'hA5) begin
            n_fail++;
            $display("FAIL single_strobe: got wr=%b data=%h expected wr=1 data=a5", Tx_WR, Tx_DATA);
        end
        for (int i = 0; i < 40 && busy !== 1'b0; i++) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || fifo_count !== 5'd0) begin
            n_fail++;
            $display("FAIL single_idle: got busy=%b count=%0d expected 0,0", busy, fifo_count);
        end
        n_checks++;
        if (cycle != c0 + b + 4) begin
            n_fail++;
            $display("FAIL single_idle_time: got cycle %0d expected %0d", cycle - c0, b + 4);
        end
    endtask

    task automatic test_burst();
        int b;
        do_reset();
        b = $urandom_range(2, 10);
        busy_len = b;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            dec_byte  = 8'(i);
            dec_valid = 1'b1;
        end
        @(negedge clk);
        dec_valid = 1'b0;
        wait_rx(5, 5 * (b + 5) + 40);
        repeat (b + 10) @(negedge clk);
        n_checks++;
        if (rx_data.size() != 5) begin
            n_fail++;
            $display("FAIL burst_count: got %0d strobes expected 5", rx_data.size());
        end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (i >= rx_data.size() || rx_data[i] !== 8'(i + 1)) begin
                n_fail++;
                $display("FAIL burst_data[%0d]: got %h expected %h", i,
                         (i < rx_data.size()) ? rx_data[i] : 8'hxx, 8'(i + 1));
            end
        end
        for (int i = 1; i < 5 && i < rx_cyc.size(); i++) begin
            n_checks++;
            if (rx_cyc[i] - rx_cyc[i-1] != b + 3) begin
                n_fail++;
                $display("FAIL burst_gap[%0d]: got %0d expected %0d", i,
                         rx_cyc[i] - rx_cyc[i-1], b + 3);
            end
        end
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL burst_overflow: got %b expected 0", overflow);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] exp[$];
        logic [7:0] v;
        int         b;
        do_reset();
        b = $urandom_range(2, 6);
        busy_len  = b;
        uart_hold = 1'b1;
        @(negedge clk);
        v = 8'($urandom);
        exp.push_back(v);
        dec_byte  = v;
        dec_valid = 1'b1;
        @(negedge clk);
        dec_valid = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 17; i++) begin
            v = 8'($urandom);
            if (i < 16) exp.push_back(v);
            dec_byte  = v;
            dec_valid = 1'b1;
            @(negedge clk);
        end
        dec_valid = 1'b0;
        n_checks++;
        if (fifo_count !== 5'd16 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_full: got count=%0d ovf=%b expected 16,1", fifo_count, overflow);
        end
        @(posedge clk);
        #1 uart_hold = 1'b0;
        wait_rx(17, 17 * (b + 5) + 60);
        repeat (b + 10) @(negedge clk);
        n_checks++;
        if (rx_data.size() != 17) begin
            n_fail++;
            $display("FAIL ovf_rx_count: got %0d expected 17", rx_data.size());
        end
        for (int i = 0; i < 17; i++) begin
            n_checks++;
            if (i >= rx_data.size() || rx_data[i] !== exp[i]) begin
                n_fail++;
                $display("FAIL ovf_data[%0d]: got %h expected %h", i,
                         (i < rx_data.size()) ? rx_data[i] : 8'hxx, exp[i]);
            end
        end
        n_checks++;
        if (overflow !== 1'b1 || fifo_count !== 5'd0) begin
            n_fail++;
            $display("FAIL ovf_sticky: got ovf=%b count=%0d expected 1,0", overflow, fifo_count);
        end
    endtask

    task automatic test_full_pop();
        logic [7:0] exp[$];
        logic [7:0] v;
        int         b;
        int         r;
        do_reset();
        b = $urandom_range(2, 6);
        busy_len  = b;
        uart_hold = 1'b1;
        @(negedge clk);
        v = 8'($urandom);
        exp.push_back(v);
        dec_byte  = v;
        dec_valid = 1'b1;
        @(negedge clk);
        dec_valid = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            v = 8'($urandom);
            exp.push_back(v);
            dec_byte  = v;
            dec_valid = 1'b1;
            @(negedge clk);
        end
        dec_valid = 1'b0;
        n_checks++;
        if (fifo_count !== 5'd16 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL fullpop_pre: got count=%0d ovf=%b expected 16,0", fifo_count, overflow);
        end
        @(posedge clk);
        #1;
        r = cycle;
        uart_hold = 1'b0;
        // busy seen low at end of cycle r -> IDLE r+1 -> LOAD r+2
        while (cycle != r + 2) @(negedge clk);
        v = 8'($urandom);
        exp.push_back(v);
        dec_byte  = v;
        dec_valid = 1'b1;
        @(negedge clk);
        dec_valid = 1'b0;
        n_checks++;
        if (fifo_count !== 5'd16 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL fullpop_same: got count=%0d ovf=%b expected 16,0", fifo_count, overflow);
        end
        n_checks++;
        if (Tx_WR !== 1'b1 || Tx_DATA !== exp[1]) begin
            n_fail++;
            $display("FAIL fullpop_strobe: got wr=%b data=%h expected 1,%h", Tx_WR, Tx_DATA, exp[1]);
        end
        wait_rx(18, 18 * (b + 5) + 60);
        repeat (b + 10) @(negedge clk);
        n_checks++;
        if (rx_data.size() != 18) begin
            n_fail++;
            $display("FAIL fullpop_rx_count: got %0d expected 18", rx_data.size());
        end
        for (int i = 0; i < 18; i++) begin
            n_checks++;
            if (i >= rx_data.size() || rx_data[i] !== exp[i]) begin
                n_fail++;
                $display("FAIL fullpop_data[%0d]: got %h expected %h", i,
                         (i < rx_data.size()) ? rx_data[i] : 8'hxx, exp[i]);
            end
        end
    endtask

    task automatic test_frame();
        int b;
        do_reset();
        b = $urandom_range(2, 6);
        busy_len = b;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            dec_byte  = 8'($urandom);
            dec_valid = 1'b1;
        end
        @(negedge clk);
        dec_valid = 1'b0;
        wait_rx(7, 7 * (b + 5) + 40);
        repeat (b + 10) @(negedge clk);
        n_checks++;
        if (fd_cyc.size() != 2) begin
            n_fail++;
            $display("FAIL frame_pulses7: got %0d expected 2", fd_cyc.size());
        end
        n_checks++;
        if (fd_cyc.size() < 2 || rx_cyc.size() < 6 ||
            fd_cyc[0] != rx_cyc[2] + b + 1 || fd_cyc[1] != rx_cyc[5] + b + 1) begin
            n_fail++;
            $display("FAIL frame_timing: got pulses at %p expected after strobes 3 and 6 (+%0d)",
                     fd_cyc, b + 1);
        end
        // counter holds 1 now: two more bytes complete the next frame
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            dec_byte  = 8'($urandom);
            dec_valid = 1'b1;
        end
        @(negedge clk);
        dec_valid = 1'b0;
        wait_rx(9, 2 * (b + 5) + 40);
        repeat (b + 10) @(negedge clk);
        n_checks++;
        if (fd_cyc.size() != 3 || rx_cyc.size() != 9 || fd_cyc[2] != rx_cyc[8] + b + 1) begin
            n_fail++;
            $display("FAIL frame_resume: got %0d pulses expected 3 with last after strobe 9",
                     fd_cyc.size());
        end
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        busy_len  = $urandom_range(2, 6);
        uart_hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            dec_byte  = 8'($urandom);
            dec_valid = 1'b1;
        end
        @(negedge clk);
        dec_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (fifo_count !== 5'd4 || rx_data.size() != 1) begin
            n_fail++;
            $display("FAIL rstmid_pre: got count=%0d sent=%0d expected 4,1", fifo_count, rx_data.size());
        end
        n = rx_data.size();
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        n_checks++;
        if ({Tx_DATA, Tx_WR, fifo_count, overflow, frame_done, busy} !== 17'd0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got %h,%b,%0d,%b,%b,%b expected all zero",
                     Tx_DATA, Tx_WR, fifo_count, overflow, frame_done, busy);
        end
        @(posedge clk);
        #1 uart_hold = 1'b0;
        repeat (30) @(negedge clk);
        n_checks++;
        if (rx_data.size() != n || busy !== 1'b0 || fifo_count !== 5'd0) begin
            n_fail++;
            $display("FAIL rstmid_quiet: got sent=%0d busy=%b count=%0d expected %0d,0,0",
                     rx_data.size(), busy, fifo_count, n);
        end
    endtask

    task automatic test_random_stream();
        logic [7:0] exp[$];
        logic [7:0] v;
        int         b;
        do_reset();
        b = $urandom_range(2, 6);
        busy_len = b;
        for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            for (int i = 0; i < 500 && (exp.size() - rx_data.size()) >= 8; i++) @(negedge clk);
            @(negedge clk);
            v = 8'($urandom);
            exp.push_back(v);
            dec_byte  = v;
            dec_valid = 1'b1;
            @(negedge clk);
            dec_valid = 1'b0;
        end
        wait_rx(40, 40 * (b + 5) + 60);
        repeat (b + 10) @(negedge clk);
        n_checks++;
        if (rx_data.size() != 40) begin
            n_fail++;
            $display("FAIL stream_count: got %0d expected 40", rx_data.size());
        end
        for (int i = 0; i < 40; i++) begin
            n_checks++;
            if (i >= rx_data.size() || rx_data[i] !== exp[i]) begin
                n_fail++;
                $display("FAIL stream_data[%0d]: got %h expected %h", i,
                         (i < rx_data.size()) ? rx_data[i] : 8'hxx, exp[i]);
            end
        end
        n_checks++;
        if (overflow !== 1'b0 || busy !== 1'b0 || fifo_count !== 5'd0) begin
            n_fail++;
            $display("FAIL stream_end: got ovf=%b busy=%b count=%0d expected 0,0,0",
                     overflow, busy, fifo_count);
        end
    endtask

    initial begin
        reset     = 1'b1;
        dec_byte  = 8'd0;
        dec_valid = 1'b0;
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_full_pop();
        test_frame();
        test_reset_mid();
        test_random_stream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
